// File: rtl/cntreg_timer.sv
// Bus-addressed up/down counter/timer with prescaler, reload, one-shot/periodic mode and wrap interrupt.
// Define CNTREG_TIMER_EVENT_EN to add synchronized external-event counting (CTRL.ext).
module cntreg_timer #(
  parameter int WIDTH = 32,
  parameter int PSW   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq,
  input  logic             ev_in
);

  localparam logic [1:0] ADDR_CNT    = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STAT   = 2'd3;

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] cnt_next;
  logic [PSW-1:0]   pre_reg;
  logic [PSW-1:0]   psc_reg;
  logic [PSW-1:0]   psc_next;
  logic             run_reg;
  logic             down_reg;
  logic             ar_reg;
  logic             ie_reg;
  logic             wrap_reg;
  logic             irq_reg;

  logic wr_cnt;
  logic wr_reload;
  logic wr_ctrl;
  logic wr_stat;
  logic ext;
  logic ev_tick;
  logic advance;
  logic psc_hit;
  logic step;
  logic wrap_ev;
  logic [WIDTH-1:0] ctrl_word;
  logic [WIDTH-1:0] stat_word;

  assign wr_cnt    = wen && (addr == ADDR_CNT);
  assign wr_reload = wen && (addr == ADDR_RELOAD);
  assign wr_ctrl   = wen && (addr == ADDR_CTRL);
  assign wr_stat   = wen && (addr == ADDR_STAT);

`ifdef CNTREG_TIMER_EVENT_EN
  logic       ext_reg;
  logic [2:0] ev_sync_reg;

  // Two synchronizer flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_sync_reg <= '0;
      ext_reg     <= 1'b0;
    end else begin
      ev_sync_reg <= {ev_sync_reg[1:0], ev_in};
      if (wr_ctrl)
        ext_reg <= din[4];
    end
  end

  assign ext     = ext_reg;
  assign ev_tick = ev_sync_reg[1] & ~ev_sync_reg[2];
`else
  logic unused_ev;
  assign unused_ev = ev_in;
  assign ext       = 1'b0;
  assign ev_tick   = 1'b0;
`endif

  assign advance = run_reg && (ext ? ev_tick : 1'b1);
  assign psc_hit = advance && (psc_reg == pre_reg);
  assign step    = psc_hit && !wr_cnt;

  always_comb begin
    psc_next = psc_reg;
    if (wr_ctrl || wr_cnt || !run_reg)
      psc_next = '0;
    else if (advance)
      psc_next = psc_hit ? '0 : psc_reg + 1'b1;
  end

  // A CNT write overrides any step in the same cycle.
  always_comb begin
    cnt_next = cnt_reg;
    wrap_ev  = 1'b0;
    if (wr_cnt) begin
      cnt_next = din;
    end else if (step) begin
      if (down_reg) begin
        if (cnt_reg == '0) begin
          cnt_next = reload_reg;
          wrap_ev  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end else begin
        if (cnt_reg == reload_reg) begin
          cnt_next = '0;
          wrap_ev  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      reload_reg <= '1;
      run_reg    <= 1'b0;
      down_reg   <= 1'b0;
      ar_reg     <= 1'b0;
      ie_reg     <= 1'b0;
      pre_reg    <= '0;
      psc_reg    <= '0;
      wrap_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      psc_reg <= psc_next;
      if (wr_reload)
        reload_reg <= din;
      if (wr_ctrl) begin
        run_reg  <= din[0];
        down_reg <= din[1];
        ar_reg   <= din[2];
        ie_reg   <= din[3];
        pre_reg  <= din[8 +: PSW];
      end else if (wrap_ev && !ar_reg) begin
        run_reg <= 1'b0;
      end
      // A wrap in the same cycle as a STAT clear leaves the flag set.
      wrap_reg <= wrap_ev | (wrap_reg & ~(wr_stat & din[0]));
      irq_reg  <= wrap_reg & ie_reg;
    end
  end

  assign irq = irq_reg;

  always_comb begin
    ctrl_word           = '0;
    ctrl_word[0]        = run_reg;
    ctrl_word[1]        = down_reg;
    ctrl_word[2]        = ar_reg;
    ctrl_word[3]        = ie_reg;
    ctrl_word[4]        = ext;
    ctrl_word[8 +: PSW] = pre_reg;
    stat_word           = '0;
    stat_word[0]        = wrap_reg;
    stat_word[1]        = run_reg;
  end

  always_comb begin
    case (addr)
      ADDR_CNT:    dout = cnt_reg;
      ADDR_RELOAD: dout = reload_reg;
      ADDR_CTRL:   dout = ctrl_word;
      default:     dout = stat_word;
    endcase
  end

endmodule

// File: tb/tb_cntreg_timer.sv
// Directed bench for cntreg_timer: vector table for the main flows, hand sequences for corner cases.
module tb_cntreg_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        wen;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  logic        ev_in;

  int tests;
  int fails;

  cntreg_timer #(.WIDTH(32), .PSW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wen   (wen),
    .din   (din),
    .dout  (dout),
    .irq   (irq),
    .ev_in (ev_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One clock edge with an optional write, then select raddr for readback.
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
    @(negedge clk);
    wen  = w;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    wen  = 1'b0;
    addr = ra;
    #1;
  endtask

  task automatic rd(input logic [1:0] ra);
    addr = ra;
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ev_in = 1'b1;
      repeat (2) @(negedge clk);
      ev_in = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    wen   = 1'b0;
    addr  = 2'd0;
    din   = '0;
    ev_in = 1'b0;

    // Up periodic, RELOAD=3, run|ar|ie, pre=0
    vt.push_back('{1'b1, 2'd1, 32'd3,     2'd1, 32'd3, 1'b0});
    vt.push_back('{1'b1, 2'd2, 32'h0D,    2'd0, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd1, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd2, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd3, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd3, 32'd3, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd1, 1'b1});
    vt.push_back('{1'b1, 2'd3, 32'd1,     2'd3, 32'd2, 1'b1});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd3, 1'b0});
    vt.push_back('{1'b1, 2'd2, 32'd0,     2'd3, 32'd1, 1'b0});
    vt.push_back('{1'b1, 2'd3, 32'd1,     2'd3, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd0, 1'b0});
    // Down one-shot, CNT=2, RELOAD=5, pre=2
    vt.push_back('{1'b1, 2'd0, 32'd2,     2'd0, 32'd2, 1'b0});
    vt.push_back('{1'b1, 2'd1, 32'd5,     2'd1, 32'd5, 1'b0});
    vt.push_back('{1'b1, 2'd2, 32'h203,   2'd2, 32'h203, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd2, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd2, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd1, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd1, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd1, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd3, 32'd1, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd5, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd5, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd0, 32'd5, 1'b0});
    vt.push_back('{1'b1, 2'd3, 32'd1,     2'd3, 32'd0, 1'b0});
    vt.push_back('{1'b0, 2'd0, 32'd0,     2'd2, 32'h202, 1'b0});

    // Reset values while reset is held
    #2;
    rd(2'd0); chk("rst_cnt", dout, 32'd0);
    rd(2'd1); chk("rst_reload", dout, 32'hFFFF_FFFF);
    rd(2'd2); chk("rst_ctrl", dout, 32'd0);
    rd(2'd3); chk("rst_stat", dout, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      cyc(vt[i].wen, vt[i].addr, vt[i].din, vt[i].raddr);
      chk($sformatf("vec%0d_dout", i), dout, vt[i].exp);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
    end

    // CNT write beats a step on the same edge
    cyc(1'b1, 2'd1, 32'hFF, 2'd0);
    cyc(1'b1, 2'd0, 32'd0, 2'd0);
    cyc(1'b1, 2'd2, 32'h5, 2'd0);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("col_step1", dout, 32'd1);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("col_step2", dout, 32'd2);
    cyc(1'b1, 2'd0, 32'h10, 2'd0); chk("col_cntwr", dout, 32'h10);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("col_after", dout, 32'h11);

    // Wrap beats STAT clear on the same edge
    cyc(1'b1, 2'd2, 32'd0, 2'd0);
    cyc(1'b1, 2'd1, 32'd3, 2'd0);
    cyc(1'b1, 2'd0, 32'd3, 2'd0);
    cyc(1'b1, 2'd2, 32'h5, 2'd0);
    cyc(1'b1, 2'd3, 32'd1, 2'd3); chk("col_wrap_stat", dout, 32'd3);
    rd(2'd0); chk("col_wrap_cnt", dout, 32'd0);
    cyc(1'b1, 2'd2, 32'd0, 2'd0);
    cyc(1'b1, 2'd3, 32'd1, 2'd3); chk("col_stat_clr", dout, 32'd0);

    // Up counting past RELOAD rolls over without a wrap
    cyc(1'b1, 2'd1, 32'd4, 2'd0);
    cyc(1'b1, 2'd0, 32'hFFFF_FFFE, 2'd0);
    cyc(1'b1, 2'd2, 32'hD, 2'd0); chk("past_start", dout, 32'hFFFF_FFFE);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("past_max", dout, 32'hFFFF_FFFF);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("past_roll", dout, 32'd0);
    rd(2'd3); chk("past_nowrap", dout, 32'd2);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 2'd0, 32'd0, 2'd0);
      chk($sformatf("past_cnt%0d", k), dout, k);
    end
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("past_wrap_cnt", dout, 32'd0);
    rd(2'd3); chk("past_wrap_stat", dout, 32'd3);
    chk("past_irq_lag", {31'd0, irq}, 32'd0);
    cyc(1'b0, 2'd0, 32'd0, 2'd0); chk("past_cnt_next", dout, 32'd1);
    chk("past_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-count, checked before the next clock edge
    reset = 1'b1;
    #1;
    rd(2'd0); chk("arst_cnt", dout, 32'd0);
    rd(2'd1); chk("arst_reload", dout, 32'hFFFF_FFFF);
    rd(2'd2); chk("arst_ctrl", dout, 32'd0);
    rd(2'd3); chk("arst_stat", dout, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cyc(1'b0, 2'd0, 32'd0, 2'd0);
    chk("arst_idle_cnt", dout, 32'd0);

`ifdef CNTREG_TIMER_EVENT_EN
    cyc(1'b1, 2'd0, 32'd0, 2'd0);
    cyc(1'b1, 2'd2, 32'h111, 2'd2); chk("ev_ctrl", dout, 32'h111);
    pulses(4);
    repeat (4) cyc(1'b0, 2'd0, 32'd0, 2'd0);
    chk("ev_cnt", dout, 32'd2);
`else
    cyc(1'b1, 2'd0, 32'h20, 2'd0);
    cyc(1'b1, 2'd2, 32'h10, 2'd2); chk("noev_ctrl", dout, 32'd0);
    pulses(4);
    cyc(1'b0, 2'd0, 32'd0, 2'd0);
    chk("noev_cnt", dout, 32'h20);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
